// File: rtl/wb_cpu_bridge.sv
// 6502-style CPU bus to classic Wishbone master bridge with a posted-write buffer.
// Define WB_CPU_BRIDGE_TIMEOUT_EN to enable the bus-timeout watchdog (abort + err_o pulse).
module wb_cpu_bridge #(
    parameter int WB_DATA_WIDTH  = 8,
    parameter int WB_ADDR_WIDTH  = 16,
    parameter int WBUF_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    output logic                           cyc_o,
    output logic                           stb_o,
    output logic                           we_o,
    output logic [WB_ADDR_WIDTH-1:0]       adr_o,
    output logic [WB_DATA_WIDTH-1:0]       dat_o,
    input  logic                           ack_i,
    input  logic [WB_DATA_WIDTH-1:0]       dat_i,
    input  logic                           cpu_valid,
    input  logic                           cpu_we,
    input  logic [WB_ADDR_WIDTH-1:0]       cpu_addr,
    input  logic [WB_DATA_WIDTH-1:0]       cpu_wdata,
    output logic [WB_DATA_WIDTH-1:0]       cpu_rdata,
    output logic                           cpu_ready,
    output logic [$clog2(WBUF_DEPTH):0]    wbuf_level,
    output logic                           err_o
);

    localparam int PTR_W = $clog2(WBUF_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(WBUF_DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
    localparam logic [1:0] READ  = 2'd2;

    logic [1:0]               state_q, state_d;
    logic                     cyc_q, cyc_d;
    logic                     we_q, we_d;
    logic [WB_ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [WB_DATA_WIDTH-1:0] dat_q, dat_d;
    logic [LVL_W-1:0]         level_q, level_d;
    logic [PTR_W-1:0]         wptr_q, wptr_d;
    logic [PTR_W-1:0]         rptr_q, rptr_d;

    logic [WB_ADDR_WIDTH-1:0] adr_mem [WBUF_DEPTH];
    logic [WB_DATA_WIDTH-1:0] dat_mem [WBUF_DEPTH];

    logic push, pop, xfer_ack, abort, done, read_done;

`ifdef WB_CPU_BRIDGE_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    // Abort on the strobe cycle that would be the TIMEOUT_CYCLES-th without ack.
    assign abort = cyc_q && !ack_i && (to_cnt_q == TO_LAST);

    always_comb begin
        to_cnt_d = to_cnt_q;
        if (state_q == IDLE) begin
            to_cnt_d = '0;
        end else if (cyc_q && !ack_i) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    assign abort = 1'b0;
`endif

    // Full check uses the registered level, so a same-cycle pop never makes room.
    assign push      = cpu_valid && cpu_we && (level_q != FULL_LVL);
    assign xfer_ack  = cyc_q && ack_i;
    assign done      = xfer_ack || abort;
    assign pop       = (state_q == WRITE) && done;
    assign read_done = (state_q == READ) && done && cpu_valid && !cpu_we;

    assign cpu_ready  = push || read_done;
    assign err_o      = abort;
    assign cyc_o      = cyc_q;
    assign stb_o      = cyc_q;
    assign we_o       = we_q;
    assign adr_o      = adr_q;
    assign dat_o      = dat_q;
    assign wbuf_level = level_q;

    always_comb begin
        cpu_rdata = '0;
        if (read_done) begin
            cpu_rdata = abort ? '1 : dat_i;
        end
    end

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        case (state_q)
            IDLE: begin
                // Buffered writes go first so a later read observes them.
                if (level_q != '0) begin
                    adr_d   = adr_mem[rptr_q];
                    dat_d   = dat_mem[rptr_q];
                    we_d    = 1'b1;
                    cyc_d   = 1'b1;
                    state_d = WRITE;
                end else if (cpu_valid && !cpu_we) begin
                    adr_d   = cpu_addr;
                    we_d    = 1'b0;
                    cyc_d   = 1'b1;
                    state_d = READ;
                end
            end
            WRITE, READ: begin
                if (done) begin
                    cyc_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                cyc_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        wptr_d  = push ? wptr_q + PTR_W'(1) : wptr_q;
        rptr_d  = pop  ? rptr_q + PTR_W'(1) : rptr_q;
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            adr_mem[wptr_q] <= cpu_addr;
            dat_mem[wptr_q] <= cpu_wdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            level_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            level_q <= level_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
        end
    end

endmodule

// File: tb/tb_wb_cpu_bridge.sv
// Scoreboard bench for wb_cpu_bridge: directed CPU traffic, queued Wishbone/readback expectations.
module tb_wb_cpu_bridge;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cyc_o, stb_o, we_o;
    logic [15:0] adr_o;
    logic [7:0]  dat_o;
    logic        ack_i;
    logic [7:0]  dat_i;
    logic        cpu_valid, cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_ready;
    logic [2:0]  wbuf_level;
    logic        err_o;

    always #5 clk_i = ~clk_i;

    wb_cpu_bridge #(
        .WB_DATA_WIDTH (8),
        .WB_ADDR_WIDTH (16),
        .WBUF_DEPTH    (4),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .cyc_o     (cyc_o),
        .stb_o     (stb_o),
        .we_o      (we_o),
        .adr_o     (adr_o),
        .dat_o     (dat_o),
        .ack_i     (ack_i),
        .dat_i     (dat_i),
        .cpu_valid (cpu_valid),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .wbuf_level(wbuf_level),
        .err_o     (err_o)
    );

    // Slave model: acks after ack_wait strobe cycles when enabled.
    logic ack_en;
    int   ack_wait;
    int   wait_cnt;
    assign ack_i = ack_en && stb_o && (wait_cnt >= ack_wait);

    always @(posedge clk_i) begin
        if (!stb_o || ack_i) wait_cnt <= 0;
        else                 wait_cnt <= wait_cnt + 1;
    end

    typedef struct packed {
        logic        we;
        logic [15:0] adr;
        logic [7:0]  dat;
    } wb_t;

    wb_t        wb_q[$];
    logic [7:0] rd_q[$];
    int         checks   = 0;
    int         failures = 0;
    int         err_seen = 0;
    int         stb_seen = 0;
    bit         gap_pending = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT completes a transfer.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            wb_t        e;
            logic [7:0] r;
            if (gap_pending) begin
                chk("idle_gap", cyc_o, 1'b0);
                gap_pending = 1'b0;
            end
            if (cyc_o && stb_o && ack_i) begin
                if (wb_q.size() == 0) begin
                    chk("wb_unexpected", 1'b1, 1'b0);
                end else begin
                    e = wb_q.pop_front();
                    chk("wb_we", we_o, e.we);
                    chk("wb_adr", adr_o, e.adr);
                    if (e.we) chk("wb_dat", dat_o, e.dat);
                    $display("wb   we=%0d adr=0x%04h dat=0x%02h", we_o, adr_o, we_o ? dat_o : dat_i);
                end
                gap_pending = 1'b1;
            end
            if (cpu_valid && cpu_ready && !cpu_we) begin
                if (rd_q.size() == 0) begin
                    chk("rd_unexpected", 1'b1, 1'b0);
                end else begin
                    r = rd_q.pop_front();
                    chk("rd_data", cpu_rdata, r);
                    chk("rd_ack", ack_i || err_o, 1'b1);
                    $display("cpu  read adr=0x%04h rdata=0x%02h", cpu_addr, cpu_rdata);
                end
            end
            if (err_o) err_seen++;
            if (stb_o) stb_seen++;
        end
    end

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, input int budget,
                             output int waited);
        cpu_valid = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
        waited = 0;
        wb_q.push_back({1'b1, a, d});
        forever begin
            @(negedge clk_i);
            if (cpu_ready) break;
            waited++;
            if (waited > budget) begin
                chk("write_timeout", 1'b1, 1'b0);
                break;
            end
        end
        $display("cpu  write adr=0x%04h wdata=0x%02h waited=%0d", a, d, waited);
        @(posedge clk_i); #1;
        cpu_valid = 1'b0; cpu_we = 1'b0;
    endtask

    task automatic cpu_read(input logic [15:0] a, input logic [7:0] exp, input int budget,
                            output int waited);
        cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = a;
        waited = 0;
        wb_q.push_back({1'b0, a, 8'h00});
        rd_q.push_back(exp);
        forever begin
            @(negedge clk_i);
            if (cpu_ready) break;
            waited++;
            if (waited > budget) begin
                chk("read_timeout", 1'b1, 1'b0);
                break;
            end
        end
        @(posedge clk_i); #1;
        cpu_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((wbuf_level != 0 || cyc_o) && n < budget) begin
            @(posedge clk_i); #1;
            n++;
        end
        chk("drain_bound", (wbuf_level == 0 && !cyc_o), 1'b1);
        @(posedge clk_i); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, w5, base;
        rst_i = 1'b1; cpu_valid = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        ack_en = 1'b0; ack_wait = 0; dat_i = '0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_cyc", cyc_o, 1'b0);
        chk("rst_stb", stb_o, 1'b0);
        chk("rst_we", we_o, 1'b0);
        chk("rst_adr", adr_o, 16'h0);
        chk("rst_dat", dat_o, 8'h0);
        chk("rst_level", wbuf_level, 3'd0);
        chk("rst_err", err_o, 1'b0);
        chk("rst_ready", cpu_ready, 1'b0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        // Reset in the middle of a buffered write burst.
        for (int i = 0; i < 3; i++) begin
            cpu_write(16'h0100 + 16'(i), 8'h11 + 8'(i), 10, w);
        end
        @(negedge clk_i);
        chk("pre_rst_cyc", cyc_o, 1'b1);
        chk("pre_rst_we", we_o, 1'b1);
        chk("pre_rst_adr", adr_o, 16'h0100);
        chk("pre_rst_level", wbuf_level, 3'd3);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        wb_q.delete();
        stb_seen = 0;
        @(negedge clk_i);
        chk("post_rst_cyc", cyc_o, 1'b0);
        chk("post_rst_level", wbuf_level, 3'd0);
        @(posedge clk_i); #1;
        repeat (10) @(posedge clk_i);
        #1;
        chk("post_rst_no_stb", stb_seen, 0);

        // Four posted writes fill the buffer; the fifth stalls until the slave acks.
        ack_en = 1'b0; ack_wait = 0;
        for (int i = 0; i < 4; i++) begin
            cpu_write(16'h1000 + 16'(i), 8'hA0 + 8'(i), 10, w);
            chk("wr_zero_wait", w, 0);
        end
        @(negedge clk_i);
        chk("full_level", wbuf_level, 3'd4);
        @(posedge clk_i); #1;
        fork
            cpu_write(16'h1004, 8'hA4, 50, w5);
            begin
                repeat (3) begin
                    @(negedge clk_i);
                    chk("full_stall", cpu_ready, 1'b0);
                end
                @(posedge clk_i); #1;
                ack_en = 1'b1;
            end
        join
        chk("stall_cycles", (w5 >= 3), 1'b1);
        wait_idle(100);
        chk("burst_drained", wb_q.size(), 0);

        // Read behind a buffered write to the same address.
        ack_en = 1'b0; dat_i = 8'h77;
        cpu_write(16'h2000, 8'h55, 10, w);
        @(posedge clk_i); #1;
        fork
            cpu_read(16'h2000, 8'h77, 100, w);
            begin
                repeat (5) begin
                    @(negedge clk_i);
                    chk("write_first", {cyc_o, we_o}, 2'b11);
                end
                @(posedge clk_i); #1;
                ack_en = 1'b1;
            end
        join
        wait_idle(50);

        // Zero-wait slave read: ready one cycle after the request.
        ack_en = 1'b1; ack_wait = 0; dat_i = 8'h3C;
        cpu_read(16'h3000, 8'h3C, 20, w);
        chk("read_latency", w, 1);
        @(negedge clk_i);
        chk("rdata_idle_zero", cpu_rdata, 8'h00);
        @(posedge clk_i); #1;

        // Wait-stated write followed by a read.
        ack_wait = 2; dat_i = 8'hC3;
        cpu_write(16'h4000, 8'h5A, 10, w);
        cpu_read(16'h4001, 8'hC3, 50, w);
        wait_idle(50);

`ifdef WB_CPU_BRIDGE_TIMEOUT_EN
        // Stuck slave: abort on the 8th strobe cycle with all-ones readback.
        base = err_seen;
        ack_en = 1'b0; ack_wait = 0;
        cpu_read(16'h5000, 8'hFF, 50, w);
        chk("abort_latency", w, 8);
        @(negedge clk_i);
        chk("abort_cyc_low", cyc_o, 1'b0);
        chk("abort_err_pulses", err_seen - base, 1);
        @(posedge clk_i); #1;

        // Ack landing in the would-be abort cycle completes normally.
        base = err_seen;
        ack_en = 1'b1; ack_wait = 7; dat_i = 8'h96;
        cpu_read(16'h5001, 8'h96, 50, w);
        chk("late_ack_latency", w, 8);
        chk("late_ack_no_err", err_seen - base, 0);
        wait_idle(50);
`else
        base = 0;
        chk("no_err_pulses", err_seen - base, 0);
`endif

        chk("wb_queue_empty", wb_q.size(), 0);
        chk("rd_queue_empty", rd_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_cpu_bridge.md
Name: wb_cpu_bridge

Overview:
Parametrised successor to the single-transfer CPU-to-Wishbone adapter: connects a 6502-style CPU bus (address/data/we plus ready) to a classic Wishbone master port. Adds a posted-write buffer, so CPU writes complete without waiting for the slave. Adds configurable data and address widths, and an optional bus-timeout watchdog. Sits between the CPU core and the SoC Wishbone interconnect.

Parameters:
WB_DATA_WIDTH, 8, data width of both the CPU and Wishbone sides
WB_ADDR_WIDTH, 16, address width of both the CPU and Wishbone sides
WBUF_DEPTH, 4, posted-write buffer entries; power of 2, minimum 2
TIMEOUT_CYCLES, 255, cycles with stb_o high and no ack_i before abort; used only with the feature enabled

Ports:
clk_i  in  1  single clock, rising edge
rst_i  in  1  synchronous active-high reset
cyc_o  out  1  Wishbone cycle, registered
stb_o  out  1  Wishbone strobe, registered, equal to cyc_o
we_o  out  1  Wishbone write enable, registered
adr_o  out  WB_ADDR_WIDTH  Wishbone address, registered
dat_o  out  WB_DATA_WIDTH  Wishbone write data, registered
ack_i  in  1  Wishbone acknowledge
dat_i  in  WB_DATA_WIDTH  Wishbone read data
cpu_valid  in  1  CPU request present
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  WB_ADDR_WIDTH  CPU address
cpu_wdata  in  WB_DATA_WIDTH  CPU write data
cpu_rdata  out  WB_DATA_WIDTH  read data, valid when cpu_ready is high on a read
cpu_ready  out  1  request completes this cycle
wbuf_level  out  $clog2(WBUF_DEPTH)+1  buffered write count, registered
err_o  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset: cyc_o/stb_o/we_o = 0; adr_o/dat_o = 0; buffer emptied, wbuf_level = 0; state IDLE; err_o = 0. Reset mid-transfer drops cyc_o/stb_o at the next edge and discards every buffered write.
- CPU contract:
  - CPU holds cpu_valid/cpu_we/cpu_addr/cpu_wdata stable until cpu_ready is high.
  - The request completes on cpu_valid && cpu_ready.
  - cpu_ready is 0 whenever cpu_valid is 0.
- Writes:
  - cpu_ready = cpu_valid && cpu_we && (wbuf_level != WBUF_DEPTH). Combinational, from the registered level.
  - On acceptance, {addr, wdata} is pushed; completion is in the same cycle (zero wait).
  - A pop in the same cycle does not free space for that cycle's push.
- Reads:
  - Not issued until the buffer is empty and the state is IDLE, so reads are ordered after all earlier writes.
  - cpu_ready = (state == READ) && ack_i. cpu_rdata = dat_i (combinational).
  - cpu_rdata = 0 outside read completion, except as noted under the optional feature.
- FSM states: IDLE, WRITE, READ.
  - IDLE, buffer not empty: load head entry to adr_o/dat_o, we_o = 1, cyc_o = stb_o = 1; go to WRITE. Buffered writes have priority over a pending read.
  - IDLE, buffer empty, cpu_valid && !cpu_we: adr_o = cpu_addr, we_o = 0, cyc_o = stb_o = 1; go to READ.
  - WRITE, ack_i: pop head, cyc_o = stb_o = 0; go to IDLE.
  - READ, ack_i: cyc_o = stb_o = 0; go to IDLE.
  - One idle cycle is guaranteed between consecutive Wishbone transfers.
- Read latency: request seen in cycle N with IDLE and an empty buffer gives stb_o high in N+1. With a zero-wait slave, cpu_ready is high in N+1.
- Buffer: circular, with read/write pointers of width $clog2(WBUF_DEPTH) that wrap modulo the depth. Level is tracked separately so full and empty are unambiguous. wbuf_level ranges 0..WBUF_DEPTH.
- ack_i is ignored while cyc_o = 0.

Optional Feature:
Macro WB_CPU_BRIDGE_TIMEOUT_EN.
- Enabled:
  - A counter clears on each new stb_o assertion and increments every cycle that stb_o && !ack_i.
  - When it reaches TIMEOUT_CYCLES, the transfer aborts: cyc_o/stb_o drop at the next edge, state goes to IDLE, and err_o pulses for 1 cycle.
  - Read abort: cpu_ready = 1 in the abort cycle with cpu_rdata = all ones.
  - Write abort: the head entry is popped and discarded.
  - An ack_i arriving in the abort cycle wins: normal completion, no err_o.
- Disabled: no counter; transfers wait indefinitely; err_o tied 0.

Test Plan:
- Reset during a WRITE with 3 entries buffered -> next cycle cyc_o = 0, wbuf_level = 0, and no further stb_o.
- 4 back-to-back writes (0x1000..0x1003, data 0xA0..0xA3) with ack_i held 0 -> 4 cpu_ready pulses, wbuf_level = 4, 5th write stalls. After ack_i = 1, the slave sees the writes in order with one idle cycle between each.
- Write 0x55 to 0x2000, then read 0x2000 while the write is still buffered -> stb_o for the read only after the write is acked; cpu_ready coincides with the read ack; cpu_rdata = dat_i.
- Read with a zero-wait slave (ack_i = 1, dat_i = 0x3C) -> cpu_ready 1 cycle after the request; cpu_rdata = 0x3C.
- TIMEOUT_EN, TIMEOUT_CYCLES = 8, read with ack_i stuck at 0 -> abort after 8 strobe cycles; cpu_rdata = 0xFF with cpu_ready = 1; one err_o pulse; cyc_o low the next cycle.
- TIMEOUT_EN, ack_i arriving exactly in the abort cycle -> normal completion, err_o stays 0.
